// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 8 blocks of 4 bytes.
// Hits are served combinationally; misses run WRITEBACK/FETCH/UPDATE against block memory.
module dcache_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

    state_e      state_q, state_d;
    logic [7:0]  valid_q, dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];
    logic        seen_busy_q;
    logic [31:0] buffer_q;

    logic [2:0]  addr_tag, idx;
    logic [4:0]  bit_base;
    logic        hit, mem_done, req;

    assign addr_tag = ADDRESS[7:5];
    assign idx      = ADDRESS[4:2];
    assign bit_base = {ADDRESS[1:0], 3'b000};
    assign req      = READ | WRITE;
    assign hit      = valid_q[idx] & (tag_q[idx] == addr_tag);
    // Completion needs busywait seen high first, so a late-raising memory is not mistaken for done.
    assign mem_done = seen_busy_q & ~MEM_BUSYWAIT;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StFetch;
                end
            end
            StWriteback: if (mem_done) state_d = StFetch;
            StFetch:     if (mem_done) state_d = StUpdate;
            StUpdate:    state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'h00;
        MEM_WRITEDATA = 32'h0;
        unique case (state_q)
            StWriteback: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = data_q[idx];
            end
            StFetch: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {addr_tag, idx};
            end
            default: ;
        endcase
        READDATA = hit ? data_q[idx][bit_base +: 8] : 8'h00;
        BUSYWAIT = ~RESET & req & ~((state_q == StIdle) & hit);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q     <= 8'h00;
            dirty_q     <= 8'h00;
            seen_busy_q <= 1'b0;
            buffer_q    <= 32'h0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= 3'h0;
                data_q[i] <= 32'h0;
            end
        end else begin
            if (state_q != state_d) begin
                seen_busy_q <= 1'b0;
            end else if ((state_q == StWriteback || state_q == StFetch) && MEM_BUSYWAIT) begin
                seen_busy_q <= 1'b1;
            end

            if (state_q == StFetch && mem_done) begin
                buffer_q <= MEM_READDATA;
            end

            if (state_q == StUpdate) begin
                data_q[idx]  <= buffer_q;
                tag_q[idx]   <= addr_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (state_q == StIdle && WRITE && hit) begin
                data_q[idx][bit_base +: 8] <= WRITEDATA;
                dirty_q[idx]               <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random loads/stores, checked
// against a flat byte-memory model plus a tag/valid/dirty bookkeeping model.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dcache_controller dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            8:       return 8'hAA;
            9:       return 8'hBB;
            10:      return 8'hCC;
            11:      return 8'hDD;
            default: return 8'(a * 37 + 11);
        endcase
    endfunction

    // Block memory: busywait rises the edge after a strobe, stays high 1..4 edges,
    // then a one-edge cooldown so a lingering strobe is not taken as a new request.
    logic [31:0] bmem [64];
    logic        mem_init = 1'b0;
    logic        mem_cool;
    int          mem_cnt;

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) begin
                bmem[i] <= {init_byte(4*i+3), init_byte(4*i+2), init_byte(4*i+1), init_byte(4*i)};
            end
            mem_init <= 1'b1;
        end
        if (RESET) begin
            MEM_BUSYWAIT <= 1'b0;
            MEM_READDATA <= 32'h0;
            mem_cool     <= 1'b0;
            mem_cnt      <= 0;
        end else if (mem_cool) begin
            mem_cool <= 1'b0;
        end else if (MEM_BUSYWAIT) begin
            if (mem_cnt == 0) begin
                MEM_BUSYWAIT <= 1'b0;
                mem_cool     <= 1'b1;
                if (MEM_WRITE) bmem[MEM_ADDRESS] <= MEM_WRITEDATA;
                else if (MEM_READ) MEM_READDATA <= bmem[MEM_ADDRESS];
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (MEM_READ || MEM_WRITE) begin
            MEM_BUSYWAIT <= 1'b1;
            mem_cnt      <= int'($urandom_range(0, 3));
        end
    end

    // Strobe monitor: counts transactions (rising strobes) and remembers their payload.
    int          wb_cnt = 0;
    int          rd_cnt = 0;
    logic [5:0]  wb_addr, rd_addr;
    logic [31:0] wb_data;
    logic        prev_w = 1'b0;
    logic        prev_r = 1'b0;

    always @(negedge CLK) begin
        if (MEM_WRITE) begin
            if (!prev_w) wb_cnt++;
            wb_addr = MEM_ADDRESS;
            wb_data = MEM_WRITEDATA;
        end
        if (MEM_READ) begin
            if (!prev_r) rd_cnt++;
            rd_addr = MEM_ADDRESS;
        end
        prev_w = MEM_WRITE;
        prev_r = MEM_READ;
    end

    // Reference model: architectural byte memory plus cache bookkeeping.
    logic [7:0] gm [256];
    logic       mv [8];
    logic       md [8];
    logic [2:0] mt [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic access(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rdata);
        logic [2:0]  ix, tg;
        logic        hit_exp, wb_exp;
        logic [7:0]  old_base;
        logic [31:0] old_blk;
        int          wb0, rd0, n;
        ix       = a[4:2];
        tg       = a[7:5];
        hit_exp  = mv[ix] && (mt[ix] == tg);
        wb_exp   = !hit_exp && mv[ix] && md[ix];
        old_base = {mt[ix], ix, 2'b00};
        old_blk  = {gm[old_base+3], gm[old_base+2], gm[old_base+1], gm[old_base]};
        wb0 = wb_cnt;
        rd0 = rd_cnt;
        @(negedge CLK);
        READ      = !is_wr;
        WRITE     = is_wr;
        ADDRESS   = a;
        WRITEDATA = d;
        #1;
        check_eq("busywait_on_request", BUSYWAIT, !hit_exp);
        n = 0;
        while (BUSYWAIT && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 200) check_eq("busywait_timeout", 1, 0);
        rdata = READDATA;
        if (!is_wr) check_eq("readdata", READDATA, gm[a]);
        @(negedge CLK);
        READ  = 1'b0;
        WRITE = 1'b0;
        check_eq("writeback_count", wb_cnt - wb0, wb_exp);
        if (wb_exp) begin
            check_eq("writeback_addr", wb_addr, old_base[7:2]);
            check_eq("writeback_data", wb_data, old_blk);
        end
        check_eq("fetch_count", rd_cnt - rd0, !hit_exp);
        if (!hit_exp) check_eq("fetch_addr", rd_addr, {tg, ix});
        if (!hit_exp) begin
            mv[ix] = 1'b1;
            mt[ix] = tg;
            md[ix] = 1'b0;
        end
        if (is_wr) begin
            gm[a]  = d;
            md[ix] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] r;
        int         n;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        for (int a = 0; a < 256; a++) gm[a] = init_byte(a);
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 3'h0;
        end
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_eq("reset_mem_read", MEM_READ, 0);
        check_eq("reset_mem_write", MEM_WRITE, 0);
        check_eq("reset_mem_address", MEM_ADDRESS, 0);
        check_eq("reset_mem_writedata", MEM_WRITEDATA, 0);
        check_eq("reset_busywait", BUSYWAIT, 0);
        check_eq("reset_readdata", READDATA, 0);

        access(0, 8'h08, 8'h00, r);
        check_eq("cold_miss_data", r, 8'hAA);
        check_eq("cold_miss_fetch_addr", rd_addr, 6'h02);
        access(0, 8'h0B, 8'h00, r);
        check_eq("read_hit_data", r, 8'hDD);
        access(1, 8'h09, 8'h55, r);
        access(0, 8'h09, 8'h00, r);
        check_eq("write_hit_readback", r, 8'h55);
        access(0, 8'h28, 8'h00, r);
        check_eq("dirty_miss_wb_addr", wb_addr, 6'h02);
        check_eq("dirty_miss_wb_data", wb_data, 32'hDDCC55AA);
        check_eq("dirty_miss_fetch_addr", rd_addr, 6'h0A);
        access(1, 8'h40, 8'h77, r);
        check_eq("write_miss_fetch_addr", rd_addr, 6'h10);
        access(0, 8'h40, 8'h00, r);
        check_eq("write_miss_readback", r, 8'h77);

        // Reset while a fetch is in flight: strobes and stall must drop without a clock edge.
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 8'h08;
        n = 0;
        while (!MEM_READ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_eq("fetch_started", MEM_READ, 1);
        #2;
        RESET = 1'b1;
        #1;
        check_eq("reset_fetch_mem_read", MEM_READ, 0);
        check_eq("reset_fetch_mem_write", MEM_WRITE, 0);
        check_eq("reset_fetch_busywait", BUSYWAIT, 0);
        @(negedge CLK);
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        // Dirty lines were dropped by reset, so the architectural view is memory again.
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0;
        end
        for (int a = 0; a < 256; a++) gm[a] = bmem[a >> 2][(a % 4) * 8 +: 8];
        access(0, 8'h08, 8'h00, r);
        check_eq("post_reset_miss_addr", rd_addr, 6'h02);
        check_eq("post_reset_data", r, 8'hAA);

        for (int k = 0; k < 400; k++) begin
            access(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), r);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the 32-bit block-wide data memory.
- Holds 8 blocks of 4 bytes.
- Serves hits without stalling and sequences write-back and fetch transactions on misses using the memory busywait handshake.
- Stalls the CPU through BUSYWAIT until each access completes.

## Interface
- Parameters: none; geometry is fixed at 8 entries × 4 bytes, 8-bit byte address, 6-bit block address.
- CLK  in  1  system clock, rising-edge active.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address: tag [7:5], index [4:2], offset [1:0].
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data; selected byte on a hit, 8'h00 otherwise.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block read strobe.
- MEM_WRITE  out  1  memory block write strobe.
- MEM_ADDRESS  out  6  memory block address.
- MEM_WRITEDATA  out  32  block written to memory; byte 0 is [7:0].
- MEM_READDATA  in  32  block returned by memory.
- MEM_BUSYWAIT  in  1  memory busy.

## Operation
- Each entry holds valid, dirty, a 3-bit tag and a 32-bit data block.
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- The CPU holds READ/WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT is high.
- READ and WRITE together: WRITE takes priority.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - Read hit: READDATA = data[index] byte at offset; no state change.
  - Write hit: at the rising edge, the byte at offset = WRITEDATA and dirty = 1.
  - Miss with valid & dirty → WRITEBACK.
  - Miss otherwise → FETCH.
- WRITEBACK:
  - Outputs: MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = data[index].
  - Exits to FETCH on completion.
- FETCH:
  - Outputs: MEM_READ = 1, MEM_ADDRESS = {ADDRESS[7:5], index}.
  - Captures MEM_READDATA into a block buffer on completion, then → UPDATE.
- UPDATE:
  - One cycle: data[index] = buffer, tag = ADDRESS[7:5], valid = 1, dirty = 0.
  - → IDLE. The access then resolves as a hit; a write sets dirty.
- Memory completion:
  - An internal flag records that MEM_BUSYWAIT was sampled high at least once in the current WRITEBACK or FETCH state.
  - Completion is the first rising edge where the flag is set and MEM_BUSYWAIT is low.
  - The flag clears on state exit. This tolerates memories that raise busywait one cycle after the strobe.
- Request dropped mid-miss: the sequence still completes, then the FSM returns to IDLE.
- BUSYWAIT = (READ | WRITE) & !(state == IDLE & hit). It is forced 0 while RESET is high.

## Timing
- FSM and cache arrays are registered on the rising CLK edge.
- MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA are decoded from state (Moore). In IDLE and UPDATE: MEM_READ = 0, MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
- READDATA and BUSYWAIT are combinational from inputs, state and the arrays.
- Hit latency: 0 stall cycles. A write hit commits at the edge where BUSYWAIT is low.
- Clean miss stall: FETCH cycles + 1 (UPDATE).
- Dirty miss stall: WRITEBACK cycles + FETCH cycles + 1.
- Reset values: state = IDLE; all valid = 0 and dirty = 0; completion flag = 0; block buffer = 0; all memory outputs = 0; BUSYWAIT = 0; READDATA = 8'h00.
- RESET asserted mid-WRITEBACK or mid-FETCH:
  - Strobes drop immediately, without waiting for CLK.
  - All entries are invalidated.
  - A partial memory write is acceptable.
  - The next access misses.

## Test plan
- Cold read miss: after reset, READ 0x08. Required: MEM_READ = 1 with MEM_ADDRESS = 6'h02. Memory returns 32'hDDCCBBAA; after UPDATE, READDATA = 8'hAA and BUSYWAIT falls.
- Read hit: READ 0x0B. Required: READDATA = 8'hDD and BUSYWAIT = 0 in the same cycle; MEM_READ never asserts.
- Write hit: WRITE 0x09 with data 8'h55. Required: no memory strobe, dirty[2] = 1; a subsequent READ 0x09 returns 8'h55.
- Dirty conflict miss: READ 0x28. Required: MEM_WRITE with MEM_ADDRESS = 6'h02 and MEM_WRITEDATA = 32'hDDCC55AA, then MEM_READ with MEM_ADDRESS = 6'h0A, then a hit with BUSYWAIT low.
- Write miss, clean: WRITE 0x40 with data 8'h77. Required: FETCH from 6'h10, then UPDATE, then the byte is written and dirty[0] = 1; READ 0x40 returns 8'h77.
- Reset mid-FETCH: assert RESET during MEM_READ. Required: MEM_READ = 0 and BUSYWAIT = 0 before the next edge; a later READ 0x08 misses again.
